// File: rtl/preamble_pkg.sv
// Shared types, frame constants and 802.11a/g training-symbol tables for the preamble generator.
package preamble_pkg;

  typedef enum logic [2:0] {StIdle, StSts, StLtsGi, StLts, StGap} state_t;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_t;

  localparam int unsigned STS_PERIOD   = 16;
  localparam int unsigned STS_LEN      = 160;
  localparam int unsigned LTS_GI_LEN   = 32;
  localparam int unsigned LTS_LEN      = 64;
  localparam int unsigned PREAMBLE_LEN = 320;

  // Table entries are in thousandths of unit amplitude; 64 LSB per milli-unit keeps peaks near 10.3k.
  function automatic iq_t mk(input int i_m, input int q_m);
    iq_t v;
    v.i = 16'(i_m * 64);
    v.q = 16'(q_m * 64);
    return v;
  endfunction

  localparam iq_t STS_ROM [STS_PERIOD] = '{
    mk(  46,   46), mk(-132,    2), mk( -13,  -79), mk( 143,  -13),
    mk(  92,    0), mk( 143,  -13), mk( -13,  -79), mk(-132,    2),
    mk(  46,   46), mk(   2, -132), mk( -79,  -13), mk( -13,  143),
    mk(   0,   92), mk( -13,  143), mk( -79,  -13), mk(   2, -132)
  };

  localparam iq_t LTS_ROM [LTS_LEN] = '{
    mk( 156,    0), mk(  -5, -120), mk(  40, -111), mk(  97,   83),
    mk(  21,   28), mk(  60,  -88), mk(-115,  -55), mk( -38, -106),
    mk(  98,  -26), mk(  53,    4), mk(   1, -115), mk(-137,  -47),
    mk(  24,  -59), mk(  59,  -15), mk( -22,  161), mk( 119,   -4),
    mk(  62,   62), mk(  37,  -98), mk( -57,  -39), mk(-131,  -65),
    mk(  82,  -92), mk(  70,  -14), mk( -60,  -81), mk( -56,   22),
    mk( -35,  151), mk(-122,   17), mk(-127,   21), mk(  75,   74),
    mk(  -3,  -54), mk( -92, -115), mk(  92, -106), mk(  12,  -98),
    mk(-156,    0), mk(  12,   98), mk(  92,  106), mk( -92,  115),
    mk(  -3,   54), mk(  75,  -74), mk(-127,  -21), mk(-122,  -17),
    mk( -35, -151), mk( -56,  -22), mk( -60,   81), mk(  70,   14),
    mk(  82,   92), mk(-131,   65), mk( -57,   39), mk(  37,   98),
    mk(  62,  -62), mk( 119,    4), mk( -22, -161), mk(  59,   15),
    mk(  24,   59), mk(-137,   47), mk(   1,  115), mk(  53,   -4),
    mk(  98,   26), mk( -38,  106), mk(-115,   55), mk(  60,   88),
    mk(  21,  -28), mk(  97,  -83), mk(  40,  111), mk(  -5,  120)
  };

endpackage

// File: rtl/preamble_generator_if.sv
// AXI-Stream sample bus carrying 32-bit {I, Q} baseband samples.
interface preamble_generator_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/preamble_rom.sv
// Training-symbol lookup: sel=0 picks the short symbol table, sel=1 the long symbol table.
module preamble_rom
  import preamble_pkg::*;
(
  input  logic       i_sel,
  input  logic [5:0] i_addr,
  output iq_t        o_iq
);

  always_comb begin
    o_iq = i_sel ? LTS_ROM[i_addr] : STS_ROM[i_addr[3:0]];
  end

endmodule

// File: rtl/preamble_generator.sv
// Emits short/long training symbols plus a zero gap as a paced AXI-Stream of scaled {I, Q} samples.
module preamble_generator
  import preamble_pkg::*;
#(
  parameter int unsigned GAP_LEN    = 480,
  parameter int unsigned SAMPLE_DIV = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 repeat_in,
  input  logic [2:0]           shift_in,
  preamble_generator_if.master sig_axis,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [15:0]          frame_cnt_out
);

  localparam int unsigned PaceW      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PaceW-1:0] PaceReload = PaceW'(SAMPLE_DIV - 1);
  localparam logic [15:0] GapLast    = 16'(GAP_LEN - 1);

  state_t           r_state;
  logic [15:0]      r_idx;
  logic [2:0]       r_shift;
  logic [PaceW-1:0] r_pace;
  logic             r_valid;
  logic [31:0]      r_data;
  logic             r_last;
  logic             r_eof;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_frame_cnt;

  logic             w_xfer;
  logic             w_eof_xfer;
  logic             w_start;
  logic             w_load;
  state_t           w_pos_state;
  logic [15:0]      w_pos_idx;
  logic [2:0]       w_pos_shift;
  state_t           w_next_state;
  logic [15:0]      w_next_idx;
  logic             w_sel;
  logic [5:0]       w_addr;
  logic             w_last;
  logic             w_eof;
  iq_t              w_rom;
  logic signed [15:0] w_i;
  logic signed [15:0] w_q;

  assign w_xfer     = r_valid & sig_axis.tready;
  assign w_eof_xfer = w_xfer & r_eof;
  assign w_start    = (start_in & ~r_busy) | (w_eof_xfer & repeat_in);

  // Position of the sample to load next; a frame start overrides it with STS index 0.
  always_comb begin
    w_pos_state = r_state;
    w_pos_idx   = r_idx;
    w_pos_shift = r_shift;
    if (w_start) begin
      w_pos_state = StSts;
      w_pos_idx   = '0;
      w_pos_shift = shift_in;
    end
    w_load = (~r_valid | w_xfer) & (r_pace == '0) & (w_pos_state != StIdle);
  end

  always_comb begin
    w_next_state = w_pos_state;
    w_next_idx   = w_pos_idx + 16'd1;
    w_sel        = 1'b0;
    w_addr       = w_pos_idx[5:0];
    w_last       = 1'b0;
    w_eof        = 1'b0;
    case (w_pos_state)
      StSts: begin
        if (w_pos_idx == 16'(STS_LEN - 1)) begin
          w_next_state = StLtsGi;
          w_next_idx   = '0;
        end
      end
      StLtsGi: begin
        w_sel  = 1'b1;
        w_addr = {1'b1, w_pos_idx[4:0]};
        if (w_pos_idx == 16'(LTS_GI_LEN - 1)) begin
          w_next_state = StLts;
          w_next_idx   = '0;
        end
      end
      StLts: begin
        w_sel = 1'b1;
        if (w_pos_idx == 16'(2 * LTS_LEN - 1)) begin
          w_last     = 1'b1;
          w_next_idx = '0;
          if (GAP_LEN > 0) begin
            w_next_state = StGap;
          end else begin
            w_next_state = StIdle;
            w_eof        = 1'b1;
          end
        end
      end
      StGap: begin
        if (w_pos_idx == GapLast) begin
          w_next_state = StIdle;
          w_next_idx   = '0;
          w_eof        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  preamble_rom u_rom (
    .i_sel  (w_sel),
    .i_addr (w_addr),
    .o_iq   (w_rom)
  );

  assign w_i = $signed(w_rom.i) >>> w_pos_shift;
  assign w_q = $signed(w_rom.q) >>> w_pos_shift;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_shift     <= '0;
      r_pace      <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_done  <= w_eof_xfer;
      r_shift <= w_pos_shift;
      if (w_eof_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_eof_xfer) begin
        r_busy <= 1'b0;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= (w_pos_state == StGap) ? 32'h0 : {w_i, w_q};
        r_last  <= w_last;
        r_eof   <= w_eof;
        r_state <= w_next_state;
        r_idx   <= w_next_idx;
        r_pace  <= PaceReload;
      end else begin
        r_state <= w_pos_state;
        r_idx   <= w_pos_idx;
        if (w_xfer) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
        if (r_pace != '0) r_pace <= r_pace - PaceW'(1);
      end
    end
  end

  assign sig_axis.tvalid = r_valid;
  assign sig_axis.tdata  = r_data;
  assign sig_axis.tlast  = r_last;
  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign frame_cnt_out   = r_frame_cnt;

endmodule

// File: tb/tb_preamble_generator.sv
// Randomized self-checking bench for preamble_generator against a frame-level reference model.
module tb_preamble_generator;
  import preamble_pkg::*;

  localparam int GapA = 480;
  localparam int DivA = 1;
  localparam int GapB = 0;
  localparam int DivB = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        rep_a = 1'b0, rep_b = 1'b0;
  logic        rdy_a = 1'b1, rdy_b = 1'b1;
  logic [2:0]  shift = 3'd0;
  logic        sel = 1'b0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] cnt_a, cnt_b;

  int errs = 0;
  int chks = 0;

  logic [31:0] q_data[$];
  logic        q_last[$];
  int          q_xcyc[$];
  int          q_rise[$];
  int          q_done[$];
  int          stall_viol;

  always #5 clk = ~clk;

  preamble_generator_if axis_a ();
  preamble_generator_if axis_b ();
  assign axis_a.tready = rdy_a;
  assign axis_b.tready = rdy_b;

  preamble_generator #(.GAP_LEN(GapA), .SAMPLE_DIV(DivA)) u_dut_a (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start_a),
    .repeat_in     (rep_a),
    .shift_in      (shift),
    .sig_axis      (axis_a),
    .busy_out      (busy_a),
    .done_out      (done_a),
    .frame_cnt_out (cnt_a)
  );

  preamble_generator #(.GAP_LEN(GapB), .SAMPLE_DIV(DivB)) u_dut_b (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start_b),
    .repeat_in     (rep_b),
    .shift_in      (shift),
    .sig_axis      (axis_b),
    .busy_out      (busy_b),
    .done_out      (done_b),
    .frame_cnt_out (cnt_b)
  );

  logic        m_valid, m_last, m_busy, m_done;
  logic [31:0] m_data;
  logic [15:0] m_cnt;
  always_comb begin
    m_valid = sel ? axis_b.tvalid : axis_a.tvalid;
    m_data  = sel ? axis_b.tdata  : axis_a.tdata;
    m_last  = sel ? axis_b.tlast  : axis_a.tlast;
    m_busy  = sel ? busy_b : busy_a;
    m_done  = sel ? done_b : done_a;
    m_cnt   = sel ? cnt_b  : cnt_a;
  end

  // Floor division by 2^sh: the amplitude backoff rounds toward minus infinity.
  function automatic int fdiv(input int v, input int sh);
    int p;
    p = 1 << sh;
    if (v >= 0) return v / p;
    return -((-v + p - 1) / p);
  endfunction

  // Expected sample at beat k of a frame: 10 short symbols, GI = second half of long symbol, 2 long.
  function automatic logic [31:0] model(input int k, input int sh);
    iq_t e;
    int  vi, vq;
    if (k < 160)      e = STS_ROM[k % 16];
    else if (k < 192) e = LTS_ROM[k - 160 + 32];
    else if (k < 320) e = LTS_ROM[(k - 192) % 64];
    else              return 32'h0;
    vi = fdiv(int'($signed(e.i)), sh);
    vq = fdiv(int'($signed(e.q)), sh);
    return {16'(vi), 16'(vq)};
  endfunction

  task automatic set_ready(input logic v);
    if (sel) rdy_b = v; else rdy_a = v;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_repeat(input logic v);
    if (sel) rep_b = v; else rep_a = v;
  endtask

  task automatic pulse_start(input logic [2:0] sh);
    @(negedge clk);
    shift = sh;
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
  endtask

  // Records beats of the selected DUT, one iteration per negedge, bounded by budget cycles.
  task automatic collect(input int n, input bit rnd, input int budget, input int tail,
                         input int mid_start, input int rep_beats);
    logic        pv, px, pl, r;
    logic [31:0] pd;
    int          got, tl;
    q_data.delete(); q_last.delete(); q_xcyc.delete(); q_rise.delete(); q_done.delete();
    stall_viol = 0;
    pv = 1'b0; px = 1'b0; pl = 1'b0; pd = '0; got = 0; tl = tail;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (m_valid) begin
        if (!pv || px) q_rise.push_back(cyc);
        else if (m_data !== pd || m_last !== pl) stall_viol++;
      end else if (pv && !px) begin
        stall_viol++;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ready(r);
      set_start(cyc == mid_start);
      set_repeat(got < rep_beats);
      if (m_valid && r) begin
        q_data.push_back(m_data);
        q_last.push_back(m_last);
        q_xcyc.push_back(cyc);
        got++;
      end
      if (m_done) q_done.push_back(cyc);
      pv = m_valid; px = m_valid && r; pd = m_data; pl = m_last;
      if (got >= n) begin
        if (tl == 0) break;
        tl--;
      end
      @(negedge clk);
    end
    set_start(1'b0);
    set_repeat(1'b0);
    set_ready(1'b1);
  endtask

  task automatic test_reset;
    @(negedge clk);
    sel = 1'b0;
    #0;
    chks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_valid_a: got %b want 0", m_valid); end
    chks++; if (m_data !== 32'h0) begin errs++; $display("FAIL rst_data_a: got %h want 0", m_data); end
    chks++; if (m_last !== 1'b0) begin errs++; $display("FAIL rst_last_a: got %b want 0", m_last); end
    chks++; if (m_busy !== 1'b0) begin errs++; $display("FAIL rst_busy_a: got %b want 0", m_busy); end
    chks++; if (m_done !== 1'b0) begin errs++; $display("FAIL rst_done_a: got %b want 0", m_done); end
    chks++; if (m_cnt !== 16'd0) begin errs++; $display("FAIL rst_cnt_a: got %0d want 0", m_cnt); end
    sel = 1'b1;
    #0;
    chks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_valid_b: got %b want 0", m_valid); end
    chks++; if (m_cnt !== 16'd0) begin errs++; $display("FAIL rst_cnt_b: got %0d want 0", m_cnt); end
    sel = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_frame;
    int flen, k;
    sel  = 1'b0;
    flen = PREAMBLE_LEN + GapA;
    pulse_start(3'd0);
    chks++; if (m_busy !== 1'b1) begin errs++; $display("FAIL sf_busy: got %b want 1", m_busy); end
    collect(flen, 1'b0, flen + 50, 2, -1, 0);
    chks++;
    if (q_data.size() != flen) begin
      errs++; $display("FAIL sf_count: got %0d want %0d", q_data.size(), flen);
    end
    for (int b = 0; b < q_data.size(); b++) begin
      k = b % flen;
      chks++;
      if (q_data[b] !== model(k, 0)) begin
        errs++; $display("FAIL sf_data[%0d]: got %h want %h", b, q_data[b], model(k, 0));
      end
      chks++;
      if (q_last[b] !== (k == 319)) begin
        errs++; $display("FAIL sf_last[%0d]: got %b want %b", b, q_last[b], (k == 319));
      end
    end
    if (q_data.size() == flen) begin
      chks++; if (q_data[16] !== q_data[0]) begin errs++; $display("FAIL sf_sts_period: got %h want %h", q_data[16], q_data[0]); end
      chks++; if (q_data[256] !== q_data[192]) begin errs++; $display("FAIL sf_lts_repeat: got %h want %h", q_data[256], q_data[192]); end
      chks++; if (q_xcyc[0] !== 0) begin errs++; $display("FAIL sf_first_latency: got %0d want 0", q_xcyc[0]); end
      chks++; if (q_xcyc[flen-1] - q_xcyc[0] !== flen - 1) begin errs++; $display("FAIL sf_back_to_back: got %0d want %0d", q_xcyc[flen-1] - q_xcyc[0], flen - 1); end
      chks++; if (q_done.size() != 1 || q_done[0] !== q_xcyc[flen-1] + 1) begin
        errs++; $display("FAIL sf_done: got %0d pulses want 1 at cycle %0d", q_done.size(), q_xcyc[flen-1] + 1);
      end
    end
    chks++; if (m_cnt !== 16'd1) begin errs++; $display("FAIL sf_frame_cnt: got %0d want 1", m_cnt); end
    chks++; if (m_busy !== 1'b0) begin errs++; $display("FAIL sf_busy_end: got %b want 0", m_busy); end
  endtask

  task automatic test_random_ready;
    int flen, k, sh;
    sel  = 1'b0;
    flen = PREAMBLE_LEN + GapA;
    sh   = int'($urandom_range(1, 7));
    pulse_start(3'(sh));
    collect(flen, 1'b1, 8 * flen, 2, -1, 0);
    chks++;
    if (q_data.size() != flen) begin
      errs++; $display("FAIL rr_count: got %0d want %0d", q_data.size(), flen);
    end
    for (int b = 0; b < q_data.size(); b++) begin
      k = b % flen;
      chks++;
      if (q_data[b] !== model(k, sh)) begin
        errs++; $display("FAIL rr_data[%0d]: got %h want %h", b, q_data[b], model(k, sh));
      end
      chks++;
      if (q_last[b] !== (k == 319)) begin
        errs++; $display("FAIL rr_last[%0d]: got %b want %b", b, q_last[b], (k == 319));
      end
    end
    chks++; if (stall_viol !== 0) begin errs++; $display("FAIL rr_stall_stable: got %0d changes want 0", stall_viol); end
    if (q_data.size() == flen) begin
      chks++; if (q_done.size() != 1 || q_done[0] !== q_xcyc[flen-1] + 1) begin
        errs++; $display("FAIL rr_done: got %0d pulses want 1 at cycle %0d", q_done.size(), q_xcyc[flen-1] + 1);
      end
    end
    chks++; if (m_cnt !== 16'd2) begin errs++; $display("FAIL rr_frame_cnt: got %0d want 2", m_cnt); end
  endtask

  task automatic test_shift_hold;
    int flen, k;
    sel  = 1'b0;
    flen = PREAMBLE_LEN + GapA;
    pulse_start(3'd2);
    shift = 3'd5;
    collect(flen, 1'b0, flen + 50, 2, -1, 0);
    chks++;
    if (q_data.size() != flen) begin
      errs++; $display("FAIL sh_count: got %0d want %0d", q_data.size(), flen);
    end
    for (int b = 0; b < q_data.size(); b++) begin
      k = b % flen;
      chks++;
      if (q_data[b] !== model(k, 2)) begin
        errs++; $display("FAIL sh_data[%0d]: got %h want %h", b, q_data[b], model(k, 2));
      end
    end
    chks++; if (m_cnt !== 16'd3) begin errs++; $display("FAIL sh_frame_cnt: got %0d want 3", m_cnt); end
    shift = 3'd0;
  endtask

  task automatic test_repeat_pacing;
    int n, k, bad, late;
    sel = 1'b1;
    n   = 3 * PREAMBLE_LEN;
    pulse_start(3'd1);
    collect(n, 1'b0, n * DivB + 100, 2, 500, 2 * PREAMBLE_LEN);
    chks++;
    if (q_data.size() != n) begin
      errs++; $display("FAIL rp_count: got %0d want %0d", q_data.size(), n);
    end
    for (int b = 0; b < q_data.size(); b++) begin
      k = b % PREAMBLE_LEN;
      chks++;
      if (q_data[b] !== model(k, 1)) begin
        errs++; $display("FAIL rp_data[%0d]: got %h want %h", b, q_data[b], model(k, 1));
      end
      chks++;
      if (q_last[b] !== (k == 319)) begin
        errs++; $display("FAIL rp_last[%0d]: got %b want %b", b, q_last[b], (k == 319));
      end
    end
    bad = 0;
    for (int i = 1; i < q_rise.size(); i++) if (q_rise[i] - q_rise[i-1] != DivB) bad++;
    chks++; if (bad !== 0) begin errs++; $display("FAIL rp_spacing: got %0d irregular gaps want 0", bad); end
    chks++; if (q_done.size() != 3) begin errs++; $display("FAIL rp_done_count: got %0d want 3", q_done.size()); end
    if (q_data.size() == n && q_done.size() == 3) begin
      for (int f = 0; f < 3; f++) begin
        chks++;
        if (q_done[f] !== q_xcyc[PREAMBLE_LEN * f + 319] + 1) begin
          errs++; $display("FAIL rp_done_after_tlast[%0d]: got %0d want %0d", f, q_done[f], q_xcyc[PREAMBLE_LEN * f + 319] + 1);
        end
      end
    end
    chks++; if (m_cnt !== 16'd3) begin errs++; $display("FAIL rp_frame_cnt: got %0d want 3", m_cnt); end
    late = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid) late++;
    end
    chks++; if (late !== 0) begin errs++; $display("FAIL rp_no_queued_start: got %0d valid cycles want 0", late); end
    chks++; if (m_busy !== 1'b0) begin errs++; $display("FAIL rp_busy_end: got %b want 0", m_busy); end
  endtask

  task automatic test_reset_mid_frame;
    sel = 1'b0;
    pulse_start(3'd0);
    collect(100, 1'b0, 200, 0, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    chks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL rm_valid: got %b want 0", m_valid); end
    chks++; if (m_busy !== 1'b0) begin errs++; $display("FAIL rm_busy: got %b want 0", m_busy); end
    chks++; if (m_cnt !== 16'd0) begin errs++; $display("FAIL rm_cnt: got %0d want 0", m_cnt); end
    chks++; if (m_done !== 1'b0) begin errs++; $display("FAIL rm_done: got %b want 0", m_done); end
    rst = 1'b0;
    pulse_start(3'd0);
    collect(5, 1'b0, 50, 0, -1, 0);
    chks++; if (q_data.size() != 5) begin errs++; $display("FAIL rm_restart_count: got %0d want 5", q_data.size()); end
    for (int b = 0; b < q_data.size(); b++) begin
      chks++;
      if (q_data[b] !== model(b, 0)) begin
        errs++; $display("FAIL rm_restart_data[%0d]: got %h want %h", b, q_data[b], model(b, 0));
      end
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    test_reset();
    test_single_frame();
    test_random_ready();
    test_shift_hold();
    test_repeat_pacing();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
